lsu_mem_access: RTL and testbench

- Execute/memory-stage load/store unit, directly downstream of instruction decode.
- Consumes the decoded mem_read/mem_write/load_type/store_type controls plus the ALU-computed effective address.
- Performs one access on a 64-bit req/ack data bus and returns write-back data to the register-file stage.
- Single outstanding transaction; valid/ready on both the upstream and downstream sides.

---
 rtl/lsu_mem_access.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_mem_access.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: load/store unit for the execute/memory stage.
// Takes one decoded memory request at a time. It performs the access on a
// 64-bit req/ack bus and returns sign- or zero-extended load data for
// write-back. Only one transaction is in flight at a time.
//
// Ports
//   clock, reset        system clock; asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   mem_read/mem_write  access enables
//   load_type           001 lb, 101 lbu, 010 lh, 110 lhu, 011 lw, 111 lwu, 100 ld
//   store_type          100 sb, 101 sh, 110 sw, 111 sd
//   addr, store_data    effective byte address, rs2 value
//   rd_idx              destination register
//   bus_*               doubleword bus; bus_req held until ack or timeout
//   out_valid/out_ready downstream handshake
//   out_rdata           extended load data (0 unless out_wen)
//   out_rd_idx, out_wen register write-back index and enable
//   out_misalign        misaligned access, no bus transaction issued
//   out_err             illegal request or bus timeout
module lsu_mem_access #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  load_type,
   input  logic [2:0]  store_type,
   input  logic [63:0] addr,
   input  logic [63:0] store_data,
   input  logic [4:0]  rd_idx,
   output logic        bus_req,
   output logic        bus_we,
   output logic [63:0] bus_addr,
   output logic [63:0] bus_wdata,
   output logic [7:0]  bus_wmask,
   input  logic        bus_ack,
   input  logic [63:0] bus_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_rdata,
   output logic [4:0]  out_rd_idx,
   output logic        out_wen,
   output logic        out_misalign,
   output logic        out_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT_CYC - 1);

   state_t      state;
   state_t      state_next;

   logic        accept;
   logic        is_illegal;
   logic        is_misalign;
   logic        is_bubble;
   logic [1:0]  acc_size;      // 0 byte, 1 half, 2 word, 3 double
   logic        acc_unsigned;
   logic [7:0]  st_mask;
   logic [63:0] st_data;

   logic        req_load;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [2:0]  req_lane;
   logic [9:0]  timer;

   logic [63:0] ld_raw;
   logic [63:0] ld_ext;

   assign in_ready  = (state == IDLE) & ~reset;
   assign accept    = in_valid & in_ready;
   assign bus_req   = (state == BUS);
   assign out_valid = (state == RESP);

   // Request decode. Store codes with bit 2 clear are not defined, so they
   // are rejected together with the explicit "none" encoding.
   always_comb begin
      acc_size     = 2'd0;
      acc_unsigned = 1'b0;
      if (mem_read) begin
         acc_size     = (load_type[1:0] == 2'b00) ? 2'd3 : (load_type[1:0] - 2'd1);
         acc_unsigned = load_type[2] & (load_type[1:0] != 2'b00);
      end else if (mem_write) begin
         acc_size = store_type[1:0];
      end

      is_illegal = (mem_read & mem_write)
                 | (mem_read & (load_type == 3'b000))
                 | (mem_write & ~store_type[2]);
      is_bubble  = ~mem_read & ~mem_write;

      case (acc_size)
         2'd0:    is_misalign = 1'b0;
         2'd1:    is_misalign = addr[0];
         2'd2:    is_misalign = |addr[1:0];
         default: is_misalign = |addr[2:0];
      endcase
   end

   // Store lane steering: strobes shifted to the byte lane, data replicated
   // across the doubleword so every lane carries the right bytes.
   always_comb begin
      case (acc_size)
         2'd0: begin
            st_mask = 8'h01 << addr[2:0];
            st_data = {8{store_data[7:0]}};
         end
         2'd1: begin
            st_mask = 8'h03 << addr[2:0];
            st_data = {4{store_data[15:0]}};
         end
         2'd2: begin
            st_mask = 8'h0F << addr[2:0];
            st_data = {2{store_data[31:0]}};
         end
         default: begin
            st_mask = 8'hFF;
            st_data = store_data;
         end
      endcase
   end

   // Load extraction from the returned doubleword.
   always_comb begin
      ld_raw = bus_rdata >> {req_lane, 3'b000};
      case (req_size)
         2'd0:    ld_ext = req_unsigned ? {56'd0, ld_raw[7:0]}  : {{56{ld_raw[7]}},  ld_raw[7:0]};
         2'd1:    ld_ext = req_unsigned ? {48'd0, ld_raw[15:0]} : {{48{ld_raw[15]}}, ld_raw[15:0]};
         2'd2:    ld_ext = req_unsigned ? {32'd0, ld_raw[31:0]} : {{32{ld_raw[31]}}, ld_raw[31:0]};
         default: ld_ext = ld_raw;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_illegal | is_misalign | is_bubble)
                  state_next = RESP;
               else
                  state_next = BUS;
            end
         end
         BUS: begin
            // ack on the final count still completes normally
            if (bus_ack || (timer == TIMER_LAST))
               state_next = RESP;
         end
         RESP: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_load     <= 1'b0;
         req_size     <= 2'd0;
         req_unsigned <= 1'b0;
         req_lane     <= 3'd0;
         timer        <= '0;
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         bus_wmask    <= '0;
         out_rdata    <= '0;
         out_rd_idx   <= '0;
         out_wen      <= 1'b0;
         out_misalign <= 1'b0;
         out_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_load     <= mem_read & ~mem_write;
                  req_size     <= acc_size;
                  req_unsigned <= acc_unsigned;
                  req_lane     <= addr[2:0];
                  timer        <= '0;
                  bus_we       <= mem_write;
                  bus_addr     <= {addr[63:3], 3'b000};
                  bus_wdata    <= mem_write ? st_data : '0;
                  bus_wmask    <= mem_write ? st_mask : '0;
                  out_rdata    <= '0;
                  out_rd_idx   <= rd_idx;
                  out_wen      <= 1'b0;
                  out_err      <= is_illegal;
                  out_misalign <= ~is_illegal & is_misalign;
               end
            end
            BUS: begin
               if (bus_ack) begin
                  if (req_load && (out_rd_idx != 5'd0)) begin
                     out_wen   <= 1'b1;
                     out_rdata <= ld_ext;
                  end
               end else if (timer == TIMER_LAST) begin
                  out_err <= 1'b1;
               end else begin
                  timer <= timer + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  load_type = '0;
   logic [2:0]  store_type = '0;
   logic [63:0] addr = '0;
   logic [63:0] store_data = '0;
   logic [4:0]  rd_idx = '0;
   logic        bus_req;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_ack = 1'b0;
   logic [63:0] bus_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_rdata;
   logic [4:0]  out_rd_idx;
   logic        out_wen;
   logic        out_misalign;
   logic        out_err;

   typedef struct packed {
      logic [63:0] rdata;
      logic [4:0]  rd;
      logic        wen;
      logic        mis;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   lsu_mem_access #(.TIMEOUT_CYC(TMO)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .mem_read(mem_read), .mem_write(mem_write),
      .load_type(load_type), .store_type(store_type),
      .addr(addr), .store_data(store_data), .rd_idx(rd_idx),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rdata(out_rdata), .out_rd_idx(out_rd_idx), .out_wen(out_wen),
      .out_misalign(out_misalign), .out_err(out_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] r, input logic [4:0] rd,
                               input logic w, input logic m, input logic e);
      exp_t x;
      x.rdata = r; x.rd = rd; x.wen = w; x.mis = m; x.err = e;
      return x;
   endfunction

   // Reference load extension written per load code from byte fields.
   function automatic logic [63:0] load_model(input logic [2:0] lt, input logic [2:0] lane,
                                              input logic [63:0] d);
      int unsigned base;
      logic [63:0] v;
      base = 8 * int'(lane);
      case (lt)
         3'b001:  v = {{56{d[base+7]}},  d[base +: 8]};
         3'b101:  v = {56'd0,            d[base +: 8]};
         3'b010:  v = {{48{d[base+15]}}, d[base +: 16]};
         3'b110:  v = {48'd0,            d[base +: 16]};
         3'b011:  v = {{32{d[base+31]}}, d[base +: 32]};
         3'b111:  v = {32'd0,            d[base +: 32]};
         default: v = d;
      endcase
      return v;
   endfunction

   // Scoreboard consumer: one pop per accepted result.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("out_rdata",    out_rdata,          e.rdata);
            check("out_rd_idx",   64'(out_rd_idx),    64'(e.rd));
            check("out_wen",      64'(out_wen),       64'(e.wen));
            check("out_misalign", 64'(out_misalign),  64'(e.mis));
            check("out_err",      64'(out_err),       64'(e.err));
         end
      end
   end

   task automatic clear_inputs();
      in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      load_type = '0; store_type = '0; addr = '0; store_data = '0; rd_idx = '0;
   endtask

   // ack_at: BUS cycle index (0-based) in which bus_ack is driven, -1 for none.
   task automatic run_txn(input logic mr, input logic mw, input logic [2:0] lt,
                          input logic [2:0] st, input logic [63:0] a, input logic [63:0] sd,
                          input logic [4:0] rd, input int ack_at, input logic [63:0] rdat,
                          input logic exp_bus, input logic chk_wr, input logic [7:0] exp_wm,
                          input logic [63:0] exp_wd, input int hold, input exp_t e);
      int guard;
      int n_req;
      guard = 0;
      @(negedge clock);
      while (!in_ready && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
      out_ready  = (hold == 0);
      mem_read   = mr;  mem_write  = mw;
      load_type  = lt;  store_type = st;
      addr       = a;   store_data = sd;  rd_idx = rd;
      in_valid   = 1'b1;
      @(posedge clock);
      sb.push_back(e);
      #1 clear_inputs();
      @(negedge clock);
      if (exp_bus) begin
         check("bus_req_first", 64'(bus_req), 64'd1);
         check("bus_addr", bus_addr, {a[63:3], 3'b000});
         check("bus_we", 64'(bus_we), 64'(mw));
         if (chk_wr) begin
            check("bus_wmask", 64'(bus_wmask), 64'(exp_wm));
            check("bus_wdata", bus_wdata, exp_wd);
         end
         n_req = 0;
         while (bus_req && n_req < 2000) begin
            if (n_req == ack_at) begin
               bus_ack   = 1'b1;
               bus_rdata = rdat;
            end else begin
               bus_rdata = {$urandom, $urandom};
            end
            n_req++;
            @(posedge clock);
            #1 bus_ack = 1'b0;
            @(negedge clock);
         end
         check("bus_req_cycles", 64'(n_req), (ack_at >= 0) ? 64'(ack_at + 1) : 64'(TMO));
      end else begin
         check("no_bus_req", 64'(bus_req), 64'd0);
      end
      check("out_valid_latency", 64'(out_valid), 64'd1);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            check("stall_valid",    64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready),  64'd0);
            check("stall_rdata",    out_rdata,      e.rdata);
            check("stall_wen",      64'(out_wen),   64'(e.wen));
            @(negedge clock);
         end
         @(posedge clock);
         #1 out_ready = 1'b1;
         @(negedge clock);
      end
   endtask

   initial begin : stim
      logic [2:0]  lt;
      logic [2:0]  st;
      logic [2:0]  lane;
      logic [63:0] a;
      logic [63:0] d;
      logic [63:0] wd;
      logic [7:0]  wm;
      logic [4:0]  rd;
      int          n;
      int          ak;

      // reset state
      repeat (2) @(negedge clock);
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_bus_req",   64'(bus_req),   64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_rdata", out_rdata,      64'd0);
      check("rst_out_flags", {61'd0, out_wen, out_misalign, out_err}, 64'd0);
      check("rst_bus_wmask", 64'(bus_wmask), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // lb with sign extension, ack in first BUS cycle
      run_txn(1, 0, 3'b001, 3'b000, 64'h0000_0000_0000_1003, 64'd0, 5'd5, 0,
              64'h0000_0000_8000_0000, 1, 0, 8'h00, 64'd0, 0,
              mk(64'hFFFF_FFFF_FFFF_FF80, 5'd5, 1, 0, 0));
      // lhu / lh at lane 6
      run_txn(1, 0, 3'b110, 3'b000, 64'h6, 64'd0, 5'd7, 0, 64'hBEEF_0000_0000_0000,
              1, 0, 8'h00, 64'd0, 0, mk(64'h0000_0000_0000_BEEF, 5'd7, 1, 0, 0));
      run_txn(1, 0, 3'b010, 3'b000, 64'h6, 64'd0, 5'd7, 0, 64'hBEEF_0000_0000_0000,
              1, 0, 8'h00, 64'd0, 0, mk(64'hFFFF_FFFF_FFFF_BEEF, 5'd7, 1, 0, 0));
      // sh at lane 2
      run_txn(0, 1, 3'b000, 3'b101, 64'h2, 64'h1234, 5'd9, 0, 64'd0,
              1, 1, 8'h0C, 64'h1234_1234_1234_1234, 0, mk(64'd0, 5'd9, 0, 0, 0));
      // misaligned sw, lh, ld: no bus access
      run_txn(0, 1, 3'b000, 3'b110, 64'h2, 64'hAAAA, 5'd3, 0, 64'd0,
              0, 0, 8'h00, 64'd0, 0, mk(64'd0, 5'd3, 0, 1, 0));
      run_txn(1, 0, 3'b010, 3'b000, 64'h1, 64'd0, 5'd4, 0, 64'd0,
              0, 0, 8'h00, 64'd0, 0, mk(64'd0, 5'd4, 0, 1, 0));
      run_txn(1, 0, 3'b100, 3'b000, 64'h4, 64'd0, 5'd4, 0, 64'd0,
              0, 0, 8'h00, 64'd0, 0, mk(64'd0, 5'd4, 0, 1, 0));
      // ld to x0: bus access, no write-back
      run_txn(1, 0, 3'b100, 3'b000, 64'h8, 64'd0, 5'd0, 1, 64'hDEAD_BEEF_0000_0001,
              1, 0, 8'h00, 64'd0, 0, mk(64'd0, 5'd0, 0, 0, 0));
      // timeout, then ack on the final count
      run_txn(1, 0, 3'b100, 3'b000, 64'h10, 64'd0, 5'd6, -1, 64'd0,
              1, 0, 8'h00, 64'd0, 0, mk(64'd0, 5'd6, 0, 0, 1));
      run_txn(1, 0, 3'b011, 3'b000, 64'h14, 64'd0, 5'd6, TMO - 1, 64'h8765_4321_0000_0000,
              1, 0, 8'h00, 64'd0, 0, mk(64'hFFFF_FFFF_8765_4321, 5'd6, 1, 0, 0));
      // illegal requests and bubble
      run_txn(1, 1, 3'b011, 3'b110, 64'h0, 64'd0, 5'd1, 0, 64'd0,
              0, 0, 8'h00, 64'd0, 0, mk(64'd0, 5'd1, 0, 0, 1));
      run_txn(1, 0, 3'b000, 3'b000, 64'h0, 64'd0, 5'd2, 0, 64'd0,
              0, 0, 8'h00, 64'd0, 0, mk(64'd0, 5'd2, 0, 0, 1));
      run_txn(0, 1, 3'b000, 3'b000, 64'h0, 64'd0, 5'd2, 0, 64'd0,
              0, 0, 8'h00, 64'd0, 0, mk(64'd0, 5'd2, 0, 0, 1));
      run_txn(0, 0, 3'b000, 3'b000, 64'h3, 64'd0, 5'd8, 0, 64'd0,
              0, 0, 8'h00, 64'd0, 0, mk(64'd0, 5'd8, 0, 0, 0));
      // back-pressure on the result
      run_txn(1, 0, 3'b101, 3'b000, 64'h1, 64'd0, 5'd11, 0, 64'h0000_0000_0000_AB00,
              1, 0, 8'h00, 64'd0, 5, mk(64'h0000_0000_0000_00AB, 5'd11, 1, 0, 0));

      // reset in the middle of a bus access
      @(negedge clock);
      mem_read = 1'b1; load_type = 3'b100; addr = 64'h40; rd_idx = 5'd3; in_valid = 1'b1;
      @(posedge clock);
      #1 clear_inputs();
      @(negedge clock);
      check("mid_bus_req", 64'(bus_req), 64'd1);
      #1 reset = 1'b1;
      #1;
      check("rst_async_bus_req",  64'(bus_req),  64'd0);
      check("rst_async_in_ready", 64'(in_ready), 64'd0);
      bus_ack = 1'b1;
      @(negedge clock);
      bus_ack = 1'b0;
      reset = 1'b0;
      repeat (4) begin
         @(negedge clock);
         check("post_rst_no_valid", 64'(out_valid), 64'd0);
      end

      // randomised aligned loads and stores against the byte-level model
      for (int i = 0; i < 16; i++) begin
         a  = {$urandom, $urandom};
         d  = {$urandom, $urandom};
         rd = 5'($urandom_range(0, 31));
         ak = $urandom_range(0, TMO - 1);
         if (i % 2 == 0) begin
            case ($urandom_range(0, 6))
               0: lt = 3'b001;  1: lt = 3'b101;  2: lt = 3'b010;  3: lt = 3'b110;
               4: lt = 3'b011;  5: lt = 3'b111;  default: lt = 3'b100;
            endcase
            n    = (lt[1:0] == 2'b00) ? 8 : (1 << (int'(lt[1:0]) - 1));
            lane = 3'($urandom_range(0, 7) & ~(n - 1));
            a[2:0] = lane;
            run_txn(1, 0, lt, 3'b000, a, 64'd0, rd, ak, d, 1, 0, 8'h00, 64'd0, 0,
                    mk((rd != 0) ? load_model(lt, lane, d) : 64'd0, rd, rd != 0, 0, 0));
         end else begin
            st   = 3'($urandom_range(4, 7));
            n    = 1 << int'(st[1:0]);
            lane = 3'($urandom_range(0, 7) & ~(n - 1));
            a[2:0] = lane;
            wm = '0;
            wd = '0;
            for (int b = 0; b < 8; b++) begin
               if (b >= int'(lane) && b < int'(lane) + n) wm[b] = 1'b1;
               wd[8*b +: 8] = d[8*(b % n) +: 8];
            end
            run_txn(0, 1, 3'b000, st, a, d, rd, ak, 64'd0, 1, 1, wm, wd, 0,
                    mk(64'd0, rd, 0, 0, 0));
         end
      end

      repeat (3) @(negedge clock);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
